// File: rtl/lsu_data_port_pkg.sv
// Shared encodings for the load/store data port: access sizes, FSM states
// and the legality checks applied to an incoming core request.
package lsu_data_port_pkg;

    localparam logic [2:0] DATA_SIZE_BYTE  = 3'd0;
    localparam logic [2:0] DATA_SIZE_HALF  = 3'd1;
    localparam logic [2:0] DATA_SIZE_WORD  = 3'd2;
    localparam logic [2:0] DATA_SIZE_UBYTE = 3'd4;
    localparam logic [2:0] DATA_SIZE_UHALF = 3'd5;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    // Only five of the eight size codes describe a real access.
    function automatic logic size_legal(input logic [2:0] size);
        return (size == DATA_SIZE_BYTE)  || (size == DATA_SIZE_HALF) ||
               (size == DATA_SIZE_WORD)  || (size == DATA_SIZE_UBYTE) ||
               (size == DATA_SIZE_UHALF);
    endfunction

    // Halves need an even address, words a 4-byte aligned one.
    function automatic logic addr_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            DATA_SIZE_HALF, DATA_SIZE_UHALF: bad = addr_lo[0];
            DATA_SIZE_WORD:                  bad = (addr_lo != 2'b00);
            default:                         bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_data_port_if.sv
// Word-aligned data-memory bus: request/accept handshake plus read return.
interface lsu_data_port_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic        mem_ready_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
        input  mem_ready_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
        output mem_ready_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/lsu_data_port_lane_align.sv
// Byte-lane steering: store byte enables / replicated write data, and
// extraction plus sign/zero extension of the addressed lane on loads.
module lsu_data_port_lane_align
    import lsu_data_port_pkg::*;
(
    input  logic [2:0]  st_size_i,
    input  logic [1:0]  st_addr_lo_i,
    input  logic [31:0] st_wd_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wd_o,
    input  logic [2:0]  ld_size_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [4:0]  ld_shift;
    logic [31:0] ld_lane;

    // Store side: enable only the addressed lanes, replicate data across the word.
    always_comb begin
        st_be_o = 4'b1111;
        st_wd_o = st_wd_i;
        case (st_size_i)
            DATA_SIZE_BYTE, DATA_SIZE_UBYTE: begin
                st_be_o = 4'b0001 << st_addr_lo_i;
                st_wd_o = {4{st_wd_i[7:0]}};
            end
            DATA_SIZE_HALF, DATA_SIZE_UHALF: begin
                st_be_o = 4'b0011 << {st_addr_lo_i[1], 1'b0};
                st_wd_o = {2{st_wd_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Load side: shift the addressed lane down to bit 0, then extend; bit 2 of size marks unsigned.
    always_comb begin
        ld_shift  = 5'd0;
        ld_lane   = ld_rdata_i;
        ld_data_o = ld_rdata_i;
        case (ld_size_i)
            DATA_SIZE_BYTE, DATA_SIZE_UBYTE: begin
                ld_shift  = {ld_addr_lo_i, 3'b000};
                ld_lane   = ld_rdata_i >> ld_shift;
                ld_data_o = {{24{ld_lane[7] & ~ld_size_i[2]}}, ld_lane[7:0]};
            end
            DATA_SIZE_HALF, DATA_SIZE_UHALF: begin
                ld_shift  = {ld_addr_lo_i[1], 4'b0000};
                ld_lane   = ld_rdata_i >> ld_shift;
                ld_data_o = {{16{ld_lane[15] & ~ld_size_i[2]}}, ld_lane[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_data_port.sv
// Load/store data port: turns one core load/store into a single handshaked
// word-aligned bus transaction, stalling the core until it completes.
module lsu_data_port
    import lsu_data_port_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   core_req_i,
    input  logic                   core_we_i,
    input  logic [2:0]             core_size_i,
    input  logic [31:0]            core_addr_i,
    input  logic [31:0]            core_wd_i,
    output logic [31:0]            core_rd_o,
    output logic                   core_stall_o,
    output logic                   err_o,
    lsu_data_port_if.master        mem
);

    localparam int               CNT_W         = 16;
    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               TIMEOUT_EN    = (TIMEOUT_CYCLES != 0);

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [31:0]       rd_q, rd_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wd_q, mem_wd_d;
    logic              req_legal, limit_hit;
    logic [3:0]        st_be;
    logic [31:0]       st_wd, ld_data;

    assign req_legal = size_legal(core_size_i) && !addr_misaligned(core_size_i, core_addr_i[1:0]);

    lsu_data_port_lane_align u_lane_align (
        .st_size_i    (core_size_i),
        .st_addr_lo_i (core_addr_i[1:0]),
        .st_wd_i      (core_wd_i),
        .st_be_o      (st_be),
        .st_wd_o      (st_wd),
        .ld_size_i    (size_q),
        .ld_addr_lo_i (addr_lo_q),
        .ld_rdata_i   (mem.mem_rdata_i),
        .ld_data_o    (ld_data)
    );

    // Next-state, bus register and stall/error decode for the access FSM.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        addr_lo_d    = addr_lo_q;
        cnt_d        = cnt_q;
        rd_d         = rd_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wd_d     = mem_wd_q;
        core_stall_o = 1'b0;
        err_o        = 1'b0;
        cnt_inc      = cnt_q + CNT_W'(1);
        limit_hit    = TIMEOUT_EN && (cnt_inc == TIMEOUT_LIMIT);
        case (state_q)
            LSU_IDLE: begin
                if (core_req_i) begin
                    if (!req_legal) begin
                        err_o = 1'b1;
                    end else begin
                        core_stall_o = 1'b1;
                        we_d         = core_we_i;
                        size_d       = core_size_i;
                        addr_lo_d    = core_addr_i[1:0];
                        cnt_d        = '0;
                        mem_req_d    = 1'b1;
                        mem_we_d     = core_we_i;
                        mem_be_d     = st_be;
                        mem_addr_d   = {core_addr_i[31:2], 2'b00};
                        mem_wd_d     = st_wd;
                        state_d      = LSU_REQ;
                    end
                end
            end
            LSU_REQ: begin
                core_stall_o = 1'b1;
                cnt_d        = cnt_inc;
                if (mem.mem_ready_i || limit_hit) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    mem_be_d  = 4'b0000;
                end
                // An accepted store finishes even on the last budget cycle; a load still needs its data.
                if (mem.mem_ready_i && we_q) begin
                    state_d = LSU_DONE;
                end else if (limit_hit) begin
                    err_o   = 1'b1;
                    rd_d    = '0;
                    state_d = LSU_DONE;
                end else if (mem.mem_ready_i) begin
                    state_d = LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                core_stall_o = 1'b1;
                cnt_d        = cnt_inc;
                if (mem.mem_rvalid_i) begin
                    rd_d    = ld_data;
                    state_d = LSU_DONE;
                end else if (limit_hit) begin
                    err_o   = 1'b1;
                    rd_d    = '0;
                    state_d = LSU_DONE;
                end
            end
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    // State and registered bus/result outputs; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LSU_IDLE;
            we_q       <= 1'b0;
            size_q     <= 3'd0;
            addr_lo_q  <= 2'd0;
            cnt_q      <= '0;
            rd_q       <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_be_q   <= 4'b0000;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            size_q     <= size_d;
            addr_lo_q  <= addr_lo_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_be_q   <= mem_be_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
        end
    end

    assign core_rd_o      = rd_q;
    assign mem.mem_req_o  = mem_req_q;
    assign mem.mem_we_o   = mem_we_q;
    assign mem.mem_be_o   = mem_be_q;
    assign mem.mem_addr_o = mem_addr_q;
    assign mem.mem_wd_o   = mem_wd_q;

endmodule

// File: tb/tb_lsu_data_port.sv
// Scoreboard bench for lsu_data_port: directed and random loads/stores with a
// behavioural slave; expectations queued at issue, checked by a monitor.
module tb_lsu_data_port;

    localparam int TO = 4;

    typedef struct {
        int          kind;   // 0 rejected, 1 completes, 2 times out
        logic        acc;    // bus handshake expected
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_req, core_we;
    logic [2:0]  core_size;
    logic [31:0] core_addr, core_wd, core_rd;
    logic        core_stall, err;
    logic [31:0] model_rd;
    int          vectors = 0;
    int          miscompares = 0;
    int          txn_no = 0;
    exp_t        exp_q[$];

    lsu_data_port_if bus();

    lsu_data_port #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .core_req_i   (core_req),
        .core_we_i    (core_we),
        .core_size_i  (core_size),
        .core_addr_i  (core_addr),
        .core_wd_i    (core_wd),
        .core_rd_o    (core_rd),
        .core_stall_o (core_stall),
        .err_o        (err),
        .mem          (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Issue one access; also plays the slave using the planned ready delay and read latency.
    task automatic do_txn(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input int rdy, input int lat, input logic [31:0] rdata);
        exp_t        e;
        int          nb, o;
        logic        legal;
        logic [31:0] v, mask, m;
        legal = (size inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if ((size == 3'd1 || size == 3'd5) && (addr % 2 != 0)) legal = 1'b0;
        if (size == 3'd2 && (addr % 4 != 0)) legal = 1'b0;
        nb     = 1 << (size % 4);
        o      = int'(addr % 4);
        m      = ((32'd1 << nb) - 1) << o;
        e.we   = we;
        e.addr = addr & 32'hFFFF_FFFC;
        e.be   = m[3:0];
        e.wd   = (nb == 1) ? {24'b0, wd[7:0]} * 32'h0101_0101 :
                 (nb == 2) ? {16'b0, wd[15:0]} * 32'h0001_0001 : wd;
        mask   = (nb == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 1;
        v      = (rdata >> (8 * o)) & mask;
        if (size < 3'd4 && nb < 4 && v[8*nb-1]) v = v | ~mask;
        e.acc  = legal && (rdy < TO);
        if (!legal) e.kind = 0;
        else if (we) e.kind = (rdy < TO) ? 1 : 2;
        else e.kind = (rdy + lat < TO) ? 1 : 2;
        if (e.kind == 1 && !we) model_rd = v;
        if (e.kind == 2) model_rd = 32'd0;
        e.rd = model_rd;
        exp_q.push_back(e);

        @(posedge clk); #1;
        bus.mem_rvalid_i = 1'b0;
        core_req = 1'b1; core_we = we; core_size = size; core_addr = addr; core_wd = wd;
        if (e.kind == 0) begin
            @(posedge clk); #1;
            core_req = 1'b0;
            return;
        end
        for (int k = 0; ; k++) begin
            @(posedge clk); #1;
            core_req         = 1'b0;
            bus.mem_ready_i  = (k == rdy);
            bus.mem_rvalid_i = !we && (k == rdy + lat);
            bus.mem_rdata_i  = bus.mem_rvalid_i ? rdata : $urandom();
            @(negedge clk);
            if (!core_stall) break;
            if (k > 40) begin
                vectors++; miscompares++;
                $display("FAIL txn_bound: stall still %b after %0d cycles, required 0", core_stall, k);
                break;
            end
        end
        @(posedge clk); #1;
        bus.mem_ready_i  = 1'b0;
        // A read response arriving after a timeout must be ignored in IDLE.
        bus.mem_rvalid_i = (e.kind == 2) && !we;
        bus.mem_rdata_i  = $urandom();
    endtask

    // Monitor: compares bus handshakes, rejects and completions against the queue.
    initial begin
        exp_t e;
        logic stall_prev, acc_seen, err_seen;
        stall_prev = 1'b0; acc_seen = 1'b0; err_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0; acc_seen = 1'b0; err_seen = 1'b0;
            end else begin
                if (bus.mem_req_o && bus.mem_ready_i) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_accept", 32'd1, 32'd0);
                    end else begin
                        e = exp_q[0];
                        check("accept_allowed", {31'b0, e.acc}, 32'd1);
                        check("mem_addr", bus.mem_addr_o, e.addr);
                        check("mem_be", {28'b0, bus.mem_be_o}, {28'b0, e.be});
                        check("mem_wd", bus.mem_wd_o, e.wd);
                        check("mem_we", {31'b0, bus.mem_we_o}, {31'b0, e.we});
                        acc_seen = 1'b1;
                    end
                end
                if (err && !core_stall) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_err", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("reject_kind", 32'(e.kind), 32'd0);
                        check("reject_no_req", {31'b0, bus.mem_req_o}, 32'd0);
                        txn_no++;
                        $display("txn %0d: rejected addr=%h", txn_no, core_addr);
                    end
                end else if (err) begin
                    err_seen = 1'b1;
                end
                if (stall_prev && !core_stall) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_kind", {31'b0, e.kind != 0}, 32'd1);
                        check("timeout_err", {31'b0, err_seen}, {31'b0, e.kind == 2});
                        check("accept_seen", {31'b0, acc_seen}, {31'b0, e.acc});
                        check("core_rd", core_rd, e.rd);
                        txn_no++;
                        $display("txn %0d: %s addr=%h %s rd=%h", txn_no, e.we ? "store" : "load",
                                 e.addr, (e.kind == 2) ? "timeout" : "ok", core_rd);
                    end
                    acc_seen = 1'b0; err_seen = 1'b0;
                end
                stall_prev = core_stall;
            end
        end
    end

    // Stimulus: reset values, directed cases, random traffic, reset during WAIT.
    initial begin
        logic [31:0] a;
        exp_t        e;
        core_req = 1'b0; core_we = 1'b0; core_size = 3'd0; core_addr = '0; core_wd = '0;
        bus.mem_ready_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
        model_rd = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", {31'b0, bus.mem_req_o}, 32'd0);
        check("rst_mem_we", {31'b0, bus.mem_we_o}, 32'd0);
        check("rst_mem_be", {28'b0, bus.mem_be_o}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_stall", {31'b0, core_stall}, 32'd0);
        check("rst_core_rd", core_rd, 32'd0);
        rst_n = 1'b1;

        do_txn(1'b1, 3'd2, 32'h104, 32'hDEAD_BEEF, 0, 1, 32'h0);
        do_txn(1'b1, 3'd0, 32'h103, 32'h0000_00A5, 0, 1, 32'h0);
        do_txn(1'b0, 3'd0, 32'h102, 32'h0, 0, 2, 32'h1280_FF00);
        do_txn(1'b0, 3'd4, 32'h102, 32'h0, 0, 2, 32'h1280_FF00);
        do_txn(1'b0, 3'd5, 32'h102, 32'h0, 0, 2, 32'h1280_FF00);
        do_txn(1'b0, 3'd1, 32'h100, 32'h0, 1, 1, 32'h1280_FF00);
        do_txn(1'b0, 3'd2, 32'h101, 32'h0, 0, 1, 32'h0);
        do_txn(1'b0, 3'd3, 32'h100, 32'h0, 0, 1, 32'h0);
        do_txn(1'b0, 3'd2, 32'h100, 32'h0, 5, 1, 32'h5555_AAAA);
        do_txn(1'b1, 3'd2, 32'h108, 32'h11, 0, 1, 32'h0);
        do_txn(1'b0, 3'd2, 32'h10C, 32'h0, 1, 1, 32'h8765_4321);
        do_txn(1'b0, 3'd2, 32'h10C, 32'h0, 2, 2, 32'h0BAD_0BAD);
        do_txn(1'b1, 3'd1, 32'h106, 32'h1234_ABCD, 3, 1, 32'h0);
        do_txn(1'b0, 3'd1, 32'h106, 32'h0, 0, 3, 32'h8001_7FFF);

        for (int i = 0; i < 300; i++) begin
            a = $urandom();
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom(),
                   int'($urandom_range(0, 5)), int'($urandom_range(1, 3)), $urandom());
        end

        // Reset while a load waits for its data.
        e.kind = 1; e.acc = 1'b1; e.we = 1'b0; e.addr = 32'h200; e.be = 4'b1111; e.wd = 32'h0; e.rd = 32'h0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus.mem_rvalid_i = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h200; core_wd = 32'h0;
        @(posedge clk); #1;
        core_req = 1'b0; bus.mem_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.mem_ready_i = 1'b0;
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        model_rd = 32'd0;
        #1;
        check("rst_wait_mem_req", {31'b0, bus.mem_req_o}, 32'd0);
        check("rst_wait_stall", {31'b0, core_stall}, 32'd0);
        check("rst_wait_core_rd", core_rd, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_txn(1'b0, 3'd2, 32'h200, 32'h0, 0, 1, 32'hCAFE_F00D);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
